// File: rtl/buf_ld_if.sv
// Bundle of the load controller's command, stream, buffer write-port and
// execute-handshake signals. The controller uses the slave view; whoever
// drives commands/stream and consumes the buffer port uses the master view.
interface buf_ld_if #(
    parameter int BUF_LD_ADDR_WIDTH = 10,
    parameter int BUF_LD_DATA_WIDTH = 8,
    parameter int IN_DATA_WIDTH     = 64
);
    // tile command
    logic                         cfg_valid;
    logic                         cfg_ready;
    logic [BUF_LD_ADDR_WIDTH:0]   cfg_len;
    // wide input stream
    logic                         s_valid;
    logic                         s_ready;
    logic [IN_DATA_WIDTH-1:0]     s_data;
    // buffer write port
    logic                         buf_ld_wr_en;
    logic                         buf_ld_sel;
    logic [BUF_LD_ADDR_WIDTH-1:0] buf_ld_addr;
    logic [BUF_LD_DATA_WIDTH-1:0] buf_ld_data;
    // execute-side bank handoff
    logic                         buf_ex_sel;
    logic                         ex_bank_valid;
    logic                         ex_done;
    // status
    logic                         ld_busy;

    modport slave (
        input  cfg_valid, cfg_len, s_valid, s_data, ex_done,
        output cfg_ready, s_ready, buf_ld_wr_en, buf_ld_sel, buf_ld_addr,
               buf_ld_data, buf_ex_sel, ex_bank_valid, ld_busy
    );

    modport master (
        output cfg_valid, cfg_len, s_valid, s_data, ex_done,
        input  cfg_ready, s_ready, buf_ld_wr_en, buf_ld_sel, buf_ld_addr,
               buf_ld_data, buf_ex_sel, ex_bank_valid, ld_busy
    );
endinterface

// File: rtl/buf_ld_ctrl.sv
// Load-side controller for the ping-pong tile buffer. Takes a per-tile length
// command, unpacks wide stream words into narrow buffer writes (slice 0 first),
// tracks which of the two banks hold complete tiles and hands full banks to the
// execute side through ex_bank_valid / ex_done. All outputs come from registers.
module buf_ld_ctrl #(
    parameter int BUF_LD_ADDR_WIDTH = 10,
    parameter int BUF_LD_DATA_WIDTH = 8,
    // must be an integer multiple of BUF_LD_DATA_WIDTH
    parameter int IN_DATA_WIDTH     = 64
) (
    input  logic     clk,
    input  logic     rst,
    buf_ld_if.slave  bus
);
    localparam int RATIO = IN_DATA_WIDTH / BUF_LD_DATA_WIDTH;
    localparam int K_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CW    = BUF_LD_ADDR_WIDTH + 1;
    // largest tile a bank can hold: 2^BUF_LD_ADDR_WIDTH words
    localparam logic [CW-1:0] MAX_LEN = {1'b1, {BUF_LD_ADDR_WIDTH{1'b0}}};
    localparam logic [K_W-1:0] K_LAST = K_W'(RATIO - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BANK,
        ST_LOAD
    } state_t;

    state_t                   state_reg;
    state_t                   state_next;
    logic                     cfg_ready_reg;
    logic [CW-1:0]            len_reg;
    logic [CW-1:0]            cnt_reg;
    logic [IN_DATA_WIDTH-1:0] word_reg;
    logic                     word_valid_reg;
    logic [K_W-1:0]           k_reg;
    logic                     ld_sel_reg;
    logic                     ex_sel_reg;
    logic [1:0]               bank_full_reg;

    logic [CW-1:0]            cfg_len_clamped;
    logic                     cfg_fire;
    logic                     cfg_start;
    logic                     wr_fire;
    logic                     last_slice;
    logic                     last_write;
    logic                     more_after;
    logic                     s_ready_int;
    logic                     s_fire;
    logic                     ex_fire;
    logic [1:0]               bank_set;
    logic [1:0]               bank_clr;

    logic [BUF_LD_DATA_WIDTH-1:0] slice_arr [RATIO];

    // Narrow views of the unpack register, slice 0 in the LSBs
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
        assign slice_arr[gi] = word_reg[gi*BUF_LD_DATA_WIDTH +: BUF_LD_DATA_WIDTH];
    end

    // cfg_ready_reg is only ever high in IDLE, so it doubles as the accept gate
    assign cfg_len_clamped = (bus.cfg_len > MAX_LEN) ? MAX_LEN : bus.cfg_len;
    assign cfg_fire        = bus.cfg_valid && cfg_ready_reg;
    assign cfg_start       = cfg_fire && (cfg_len_clamped != '0);

    assign wr_fire    = (state_reg == ST_LOAD) && word_valid_reg;
    assign last_slice = (k_reg == K_LAST);
    assign last_write = wr_fire && (cnt_reg == len_reg - CW'(1));
    assign more_after = (cnt_reg + CW'(1)) < len_reg;

    // Refill either into an empty register or in the same cycle the last slice
    // is written, as long as that write is not the final one of the tile.
    assign s_ready_int = (state_reg == ST_LOAD) &&
                         (!word_valid_reg || (last_slice && more_after));
    assign s_fire      = bus.s_valid && s_ready_int;
    assign ex_fire     = bus.ex_done && bank_full_reg[ex_sel_reg];

    // Per-bank set/clear; loading only begins on a free bank so a bank is
    // never set and cleared in the same cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        assign bank_set[gi] = last_write && (ld_sel_reg == 1'(gi));
        assign bank_clr[gi] = ex_fire && (ex_sel_reg == 1'(gi));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_next = bank_full_reg[ld_sel_reg] ? ST_WAIT_BANK : ST_LOAD;
                end
            end
            ST_WAIT_BANK: begin
                if (!bank_full_reg[ld_sel_reg]) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (last_write) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: command latch, unpack register, write counter, bank bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready_reg  <= 1'b0;
            len_reg        <= '0;
            cnt_reg        <= '0;
            word_reg       <= '0;
            word_valid_reg <= 1'b0;
            k_reg          <= '0;
            ld_sel_reg     <= 1'b0;
            ex_sel_reg     <= 1'b0;
            bank_full_reg  <= 2'b00;
        end else begin
            cfg_ready_reg <= (state_next == ST_IDLE);

            if (cfg_start) begin
                len_reg <= cfg_len_clamped;
                cnt_reg <= '0;
            end

            if (wr_fire) begin
                cnt_reg <= cnt_reg + CW'(1);
                if (last_write) begin
                    // leftover slices of the final word are dropped
                    word_valid_reg <= 1'b0;
                end else if (last_slice) begin
                    if (s_fire) begin
                        word_reg <= bus.s_data;
                        k_reg    <= '0;
                    end else begin
                        word_valid_reg <= 1'b0;
                    end
                end else begin
                    k_reg <= k_reg + K_W'(1);
                end
            end else if (s_fire) begin
                word_reg       <= bus.s_data;
                k_reg          <= '0;
                word_valid_reg <= 1'b1;
            end

            if (last_write) begin
                ld_sel_reg <= ~ld_sel_reg;
            end
            if (ex_fire) begin
                ex_sel_reg <= ~ex_sel_reg;
            end
            bank_full_reg <= (bank_full_reg | bank_set) & ~bank_clr;
        end
    end

    assign bus.cfg_ready     = cfg_ready_reg;
    assign bus.s_ready       = s_ready_int;
    assign bus.buf_ld_wr_en  = wr_fire;
    assign bus.buf_ld_sel    = ld_sel_reg;
    assign bus.buf_ld_addr   = cnt_reg[BUF_LD_ADDR_WIDTH-1:0];
    assign bus.buf_ld_data   = wr_fire ? slice_arr[k_reg] : '0;
    assign bus.buf_ex_sel    = ex_sel_reg;
    assign bus.ex_bank_valid = bank_full_reg[ex_sel_reg];
    assign bus.ld_busy       = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_buf_ld_ctrl.sv
// Bench for buf_ld_ctrl: a table of tile commands with expected outcomes, a
// scoreboard queue of expected buffer writes checked on every write cycle, and
// hand-written sequences for bank back-pressure and mid-tile reset.
module tb_buf_ld_ctrl;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int IW    = 64;
    localparam int RATIO = IW / DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    buf_ld_if #(.BUF_LD_ADDR_WIDTH(AW), .BUF_LD_DATA_WIDTH(DW), .IN_DATA_WIDTH(IW)) bus ();

    buf_ld_ctrl #(.BUF_LD_ADDR_WIDTH(AW), .BUF_LD_DATA_WIDTH(DW), .IN_DATA_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [AW:0] len;
        bit          use_pat;
        logic [7:0]  pat;
        bit          stall;
        int          exp_writes;
        logic        exp_ld_sel;
        logic        exp_ex_valid;
        bit          release_bank;
        logic        exp_ex_sel_rel;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[5];
    int   vec_cnt   = 0;
    int   err_cnt   = 0;
    int   cyc       = 0;
    int   wr_total  = 0;
    int   tile_base = 0;
    int   first_cyc = 0;
    int   last_cyc  = 0;
    bit   mon_en    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every write cycle must match the head of the scoreboard
    always @(negedge clk) begin
        wr_t e;
        if (mon_en && bus.buf_ld_wr_en === 1'b1) begin
            if (wr_total == tile_base) first_cyc = cyc;
            last_cyc = cyc;
            wr_total++;
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_write: got sel %0d addr %0d data 0x%0h, required no write",
                         bus.buf_ld_sel, bus.buf_ld_addr, bus.buf_ld_data);
            end else begin
                e = exp_q.pop_front();
                chk("write sel/addr/data", {bus.buf_ld_sel, bus.buf_ld_addr, bus.buf_ld_data},
                    {e.sel, e.addr, e.data});
            end
        end
    end

    function automatic logic [DW-1:0] byte_of(input bit up, input logic [7:0] pat, input int idx);
        return up ? pat : DW'(idx);
    endfunction

    function automatic logic [IW-1:0] make_word(input int w, input bit up, input logic [7:0] pat);
        logic [IW-1:0] d;
        d = '0;
        for (int j = 0; j < RATIO; j++) d[j*DW +: DW] = byte_of(up, pat, w*RATIO + j);
        return d;
    endfunction

    task automatic push_word(input logic sel, input int w, input int lc, input bit up, input logic [7:0] pat);
        for (int j = 0; j < RATIO; j++) begin
            int idx;
            idx = w*RATIO + j;
            if (idx < lc) exp_q.push_back('{sel, AW'(idx), byte_of(up, pat, idx)});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cfg(input logic [AW:0] len);
        bit acc;
        int n;
        bus.cfg_valid = 1'b1;
        bus.cfg_len   = len;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.cfg_ready;
            step();
            n++;
        end
        bus.cfg_valid = 1'b0;
        chk("cfg accepted", acc, 1);
    endtask

    task automatic send_word(input logic [IW-1:0] d);
        bit acc;
        int n;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.s_ready;
            step();
            n++;
        end
        chk("stream word accepted", acc, 1);
    endtask

    task automatic send_tile(input logic sel, input int lc, input bit up, input logic [7:0] pat, input bit stall);
        int nw;
        nw = (lc + RATIO - 1) / RATIO;
        for (int w = 0; w < nw; w++) begin
            push_word(sel, w, lc, up, pat);
            send_word(make_word(w, up, pat));
            if (stall && (w % 2 == 0)) begin
                bus.s_valid = 1'b0;
                repeat (12) step();
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        int n;
        done = 1'b0;
        n    = 0;
        while (!done && n < 3000) begin
            step();
            n++;
            done = (bus.ld_busy === 1'b0) && (exp_q.size() == 0);
        end
        chk("load finished", done, 1);
    endtask

    task automatic pulse_ex_done();
        bus.ex_done = 1'b1;
        step();
        bus.ex_done = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lc;
        lc = (v.len > 11'd1024) ? 1024 : int'(v.len);
        tile_base = wr_total;
        issue_cfg(v.len);
        if (lc > 0) send_tile(~v.exp_ld_sel, lc, v.use_pat, v.pat, v.stall);
        wait_idle();
        $display("tile len=%0d: %0d writes, ld_sel=%0d ex_sel=%0d ex_valid=%0d",
                 v.len, wr_total - tile_base, bus.buf_ld_sel, bus.buf_ex_sel, bus.ex_bank_valid);
        chk("write count", wr_total - tile_base, v.exp_writes);
        chk("buf_ld_sel after tile", bus.buf_ld_sel, v.exp_ld_sel);
        chk("ex_bank_valid after tile", bus.ex_bank_valid, v.exp_ex_valid);
        chk("s_ready idle", bus.s_ready, 0);
        chk("cfg_ready idle", bus.cfg_ready, 1);
        if (lc > 0 && !v.stall) chk("no-bubble write span", last_cyc - first_cyc, lc - 1);
        if (v.release_bank) begin
            pulse_ex_done();
            chk("buf_ex_sel after ex_done", bus.buf_ex_sel, v.exp_ex_sel_rel);
            chk("ex_bank_valid after ex_done", bus.ex_bank_valid, 0);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst wr_en", bus.buf_ld_wr_en, 0);
        chk("rst ld_sel", bus.buf_ld_sel, 0);
        chk("rst addr", bus.buf_ld_addr, 0);
        chk("rst data", bus.buf_ld_data, 0);
        chk("rst ex_sel", bus.buf_ex_sel, 0);
        chk("rst ex_valid", bus.ex_bank_valid, 0);
        chk("rst s_ready", bus.s_ready, 0);
        chk("rst cfg_ready", bus.cfg_ready, 0);
        chk("rst ld_busy", bus.ld_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int n;
        vec_t v;

        //             len    pat?  pat    stall writes ld  exv rel exsel
        vecs[0] = '{11'd16,   0, 8'h00,  0,   16,  1,  1,  1,  1};
        vecs[1] = '{11'd5,    1, 8'h11,  0,    5,  0,  1,  1,  0};
        vecs[2] = '{11'd0,    0, 8'h00,  0,    0,  0,  0,  1,  0};
        vecs[3] = '{11'd32,   0, 8'h00,  1,   32,  1,  1,  1,  1};
        vecs[4] = '{11'd2047, 0, 8'h00,  0, 1024,  0,  1,  1,  0};

        rst = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_len   = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.ex_done   = 1'b0;
        repeat (3) step();
        chk_reset_outputs();
        mon_en = 1'b1;
        rst = 1'b0;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Both banks full, third command must park in WAIT_BANK
        v = '{11'd8, 0, 8'h00, 0, 8, 1, 1, 0, 0};
        run_vec(v);
        v = '{11'd8, 0, 8'h00, 0, 8, 0, 1, 0, 0};
        run_vec(v);
        tile_base = wr_total;
        issue_cfg(11'd8);
        chk("wait ld_busy", bus.ld_busy, 1);
        chk("wait s_ready", bus.s_ready, 0);
        chk("wait cfg_ready", bus.cfg_ready, 0);
        repeat (2) step();
        chk("wait s_ready held", bus.s_ready, 0);
        push_word(1'b0, 0, 8, 1'b0, 8'h00);
        bus.s_valid = 1'b1;
        bus.s_data  = make_word(0, 1'b0, 8'h00);
        pulse_ex_done();
        $display("ex_done in WAIT_BANK: ex_sel=%0d ex_valid=%0d s_ready=%0d",
                 bus.buf_ex_sel, bus.ex_bank_valid, bus.s_ready);
        chk("wait ex_sel toggled", bus.buf_ex_sel, 1);
        chk("wait ex_valid bank1", bus.ex_bank_valid, 1);
        chk("wait s_ready edge0", bus.s_ready, 0);
        chk("wait wr_en edge0", bus.buf_ld_wr_en, 0);
        step();
        chk("wait s_ready edge1", bus.s_ready, 1);
        chk("wait wr_en edge1", bus.buf_ld_wr_en, 0);
        step();
        bus.s_valid = 1'b0;
        chk("wait first write", {bus.buf_ld_wr_en, bus.buf_ld_sel, bus.buf_ld_addr}, {1'b1, 1'b0, 10'd0});
        wait_idle();
        chk("wait write count", wr_total - tile_base, 8);
        chk("wait ld_sel", bus.buf_ld_sel, 1);
        pulse_ex_done();
        chk("release1 ex_sel", bus.buf_ex_sel, 0);
        chk("release1 ex_valid", bus.ex_bank_valid, 1);
        pulse_ex_done();
        chk("release2 ex_sel", bus.buf_ex_sel, 1);
        chk("release2 ex_valid", bus.ex_bank_valid, 0);

        // Reset in the middle of a tile
        tile_base = wr_total;
        issue_cfg(11'd16);
        push_word(1'b1, 0, 16, 1'b0, 8'h00);
        send_word(make_word(0, 1'b0, 8'h00));
        bus.s_data = make_word(1, 1'b0, 8'h00);
        found = 1'b0;
        n = 0;
        while (!found && n < 50) begin
            if (bus.buf_ld_wr_en === 1'b1 && bus.buf_ld_addr === 10'd7) found = 1'b1;
            else begin
                step();
                n++;
            end
        end
        chk("reached addr 7", found, 1);
        rst = 1'b1;
        step();
        bus.s_valid = 1'b0;
        $display("reset at addr 7: wr_en=%0d ex_valid=%0d busy=%0d",
                 bus.buf_ld_wr_en, bus.ex_bank_valid, bus.ld_busy);
        chk_reset_outputs();
        chk("writes before reset", wr_total - tile_base, 8);
        exp_q.delete();
        rst = 1'b0;
        step();
        v = '{11'd8, 0, 8'h00, 0, 8, 1, 1, 0, 0};
        run_vec(v);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
